// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared constants and helpers for the raster timing generator.
//   - 1280x720@60 CEA timing constants (defaults of video_timing_gen)
//   - 24-bit RGB payload type and the eight test-bar colours
//   - calc_total(): sums the four regions of a line or frame
package video_timing_pkg;

  localparam int unsigned H_ACTIVE_720 = 1280;
  localparam int unsigned H_FP_720     = 110;
  localparam int unsigned H_SYNC_720   = 40;
  localparam int unsigned H_BP_720     = 220;
  localparam int unsigned V_ACTIVE_720 = 720;
  localparam int unsigned V_FP_720     = 5;
  localparam int unsigned V_SYNC_720   = 5;
  localparam int unsigned V_BP_720     = 20;
  localparam int unsigned CNT_W_720    = 12;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
  localparam rgb_t COLOR_YELLOW  = 24'hFFFF00;
  localparam rgb_t COLOR_CYAN    = 24'h00FFFF;
  localparam rgb_t COLOR_GREEN   = 24'h00FF00;
  localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
  localparam rgb_t COLOR_RED     = 24'hFF0000;
  localparam rgb_t COLOR_BLUE    = 24'h0000FF;
  localparam rgb_t COLOR_BLACK   = 24'h000000;

  // Total length of a line or frame from its four regions.
  function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Colour of bar number idx, left to right.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_color_bar_gen.sv
// color_bar_gen: eight vertical colour bars tracked with a pixel counter and a
// 3-bit bar index, no divider.
// Optional macro VTG_SCROLL_EN adds a per-frame offset that scrolls the bars
// left by one pixel per frame.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_tick   (VTG_SCROLL_EN only) last pixel of the frame
//   h_cnt        current horizontal count
//   de_i         current pixel is active video
//   rgb_c        colour of the current pixel (combinational)
module color_bar_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720,
  parameter int unsigned H_TOTAL  = 1650,
  parameter int unsigned CNT_W    = CNT_W_720
) (
  input  logic             clk,
  input  logic             rst,
`ifdef VTG_SCROLL_EN
  input  logic             frame_tick,
`endif
  input  logic [CNT_W-1:0] h_cnt,
  input  logic             de_i,
  output rgb_t             rgb_c
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] pix_cnt;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] load_pix;
  logic [2:0]       load_idx;
  logic             line_end;

  assign line_end = (h_cnt == CNT_W'(H_TOTAL - 1));

`ifdef VTG_SCROLL_EN
  // Offset held as (pixel-in-bar, bar) so it can seed the counters directly;
  // the 3-bit bar part wraps at 8 bars = H_ACTIVE.
  logic [CNT_W-1:0] off_pix, off_pix_nxt;
  logic [2:0]       off_idx, off_idx_nxt;

  always_comb begin
    off_pix_nxt = off_pix;
    off_idx_nxt = off_idx;
    if (frame_tick) begin
      if (off_pix == CNT_W'(BAR_W - 1)) begin
        off_pix_nxt = '0;
        off_idx_nxt = off_idx + 3'd1;
      end else begin
        off_pix_nxt = off_pix + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_pix <= '0;
      off_idx <= '0;
    end else begin
      off_pix <= off_pix_nxt;
      off_idx <= off_idx_nxt;
    end
  end

  // Next line starts from the offset that will be live for it.
  assign load_pix = off_pix_nxt;
  assign load_idx = off_idx_nxt;
`else
  assign load_pix = '0;
  assign load_idx = '0;
`endif

  // Counters describe the pixel at h_cnt; reloaded as the line wraps to h_cnt = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      pix_cnt <= load_pix;
      bar_idx <= load_idx;
    end else if (de_i) begin
      if (pix_cnt == CNT_W'(BAR_W - 1)) begin
        pix_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
    end
  end

  assign rgb_c = bar_color(bar_idx);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing (hsync/vsync/de) plus 8-bar test pattern,
// one pixel per pixelclk, all outputs registered with one cycle of latency.
// Optional macro VTG_SCROLL_EN: bars scroll left one pixel per frame.
// Ports:
//   pixelclk, rst_p          clock, synchronous active-high reset
//   red/green/blue_dout      pixel colour, 0 during blanking
//   hsync, vsync             syncs at SYNC_POL active level
//   de                       active video
//   x_pos, y_pos             counter position of the output pixel
//   frame_start              pulse with pixel (0,0)
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720,
  parameter int unsigned H_FP     = H_FP_720,
  parameter int unsigned H_SYNC   = H_SYNC_720,
  parameter int unsigned H_BP     = H_BP_720,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720,
  parameter int unsigned V_FP     = V_FP_720,
  parameter int unsigned V_SYNC   = V_SYNC_720,
  parameter int unsigned V_BP     = V_BP_720,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned CNT_W    = CNT_W_720
) (
  input  logic             pixelclk,
  input  logic             rst_p,
  output logic [7:0]       red_dout,
  output logic [7:0]       green_dout,
  output logic [7:0]       blue_dout,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last;
  logic             de_i, hs_i, vs_i;
  rgb_t             rgb_c;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  // Raster counters.
  always_ff @(posedge pixelclk) begin
    if (rst_p) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Region decode.
  assign de_i = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs_i = (h_cnt >= CNT_W'(H_ACTIVE + H_FP)) && (h_cnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_i = (v_cnt >= CNT_W'(V_ACTIVE + V_FP)) && (v_cnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VTG_SCROLL_EN
  logic frame_end;
  assign frame_end = h_last && v_last;
`endif

  color_bar_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .CNT_W    (CNT_W)
  ) u_bars (
    .clk        (pixelclk),
    .rst        (rst_p),
`ifdef VTG_SCROLL_EN
    .frame_tick (frame_end),
`endif
    .h_cnt      (h_cnt),
    .de_i       (de_i),
    .rgb_c      (rgb_c)
  );

  // Output registers; everything lags the counters by exactly one cycle.
  always_ff @(posedge pixelclk) begin
    if (rst_p) begin
      red_dout    <= '0;
      green_dout  <= '0;
      blue_dout   <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
    end else begin
      red_dout    <= de_i ? rgb_c.r : 8'h00;
      green_dout  <= de_i ? rgb_c.g : 8'h00;
      blue_dout   <= de_i ? rgb_c.b : 8'h00;
      hsync       <= ~(hs_i ^ SYNC_POL);
      vsync       <= ~(vs_i ^ SYNC_POL);
      de          <= de_i;
      x_pos       <= h_cnt;
      y_pos       <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two instances (small raster, active-low syncs; default
// 720p raster) checked every cycle against an arithmetic model of the raster,
// plus hand-computed literal pins. Works with or without VTG_SCROLL_EN.
module tb_video_timing_gen;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  // Small raster: 28 x 10, frame = 280 cycles, bars 2 px wide.
  localparam int S_HA = 16, S_HF = 3, S_HS = 4, S_HB = 5;
  localparam int S_VA = 5,  S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_FT = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  logic clk = 1'b0;
  logic rst_p = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  r_s, g_s, b_s, r_d, g_d, b_d;
  logic        hs_s, vs_s, de_s, fs_s, hs_d, vs_d, de_d, fs_d;
  logic [11:0] x_s, y_s, x_d, y_d;
  exp_t        got_s, got_d, exs, exd;

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b0), .CNT_W(12)
  ) dut_s (
    .pixelclk(clk), .rst_p(rst_p), .red_dout(r_s), .green_dout(g_s), .blue_dout(b_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x_pos(x_s), .y_pos(y_s), .frame_start(fs_s)
  );

  video_timing_gen dut_d (
    .pixelclk(clk), .rst_p(rst_p), .red_dout(r_d), .green_dout(g_d), .blue_dout(b_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x_pos(x_d), .y_pos(y_d), .frame_start(fs_d)
  );

  assign got_s = {r_s, g_s, b_s, hs_s, vs_s, de_s, fs_s, x_s, y_s};
  assign got_d = {r_d, g_d, b_d, hs_d, vs_d, de_d, fs_d, x_d, y_d};

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs for the t-th pixel registered since reset release.
  function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit pol, input longint t);
    exp_t   e;
    int     ht = ha + hf + hsw + hb;
    int     vt = va + vf + vsw + vb;
    longint ft = longint'(ht) * longint'(vt);
    int     p  = int'(t % ft);
    int     h  = p % ht;
    int     v  = p / ht;
    int     off = 0;
`ifdef VTG_SCROLL_EN
    off = int'((t / ft) % longint'(ha));
`endif
    e.de  = (h < ha) && (v < va);
    e.hs  = ((h >= ha + hf) && (h < ha + hf + hsw)) ? pol : !pol;
    e.vs  = ((v >= va + vf) && (v < va + vf + vsw)) ? pol : !pol;
    e.fs  = (p == 0);
    e.x   = 12'(h);
    e.y   = 12'(v);
    e.rgb = e.de ? bar_rgb(((h + off) % ha) / (ha / 8)) : 24'h0;
    return e;
  endfunction

  function automatic exp_t rst_val(input bit pol);
    exp_t e = '0;
    e.hs = !pol;
    e.vs = !pol;
    return e;
  endfunction

  int     checks = 0;
  int     failures = 0;
  longint t = -1;
  int     de_cnt = 0;
  logic   rst_seen;

  task automatic check(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
    end
  endtask

  task automatic chk_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
    end
  endtask

  // Compare process: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    rst_seen = rst_p;
    #1;
    if (rst_seen) begin
      t = -1;
      de_cnt = 0;
      exs = rst_val(1'b0);
      exd = rst_val(1'b1);
    end else begin
      t++;
      exs = model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, t);
      exd = model(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, t);
    end
    check("small_px", got_s, exs);
    check("dflt_px", got_d, exd);

    if (rst_seen) begin
      chk_lit("rst_de", 32'(de_d), 32'd0);
      chk_lit("rst_sync", 32'({hs_d, vs_d}), 32'd0);
      chk_lit("rst_rgb", 32'({r_d, g_d, b_d}), 32'd0);
    end else begin
      // De count over each complete small frame.
      if (t % S_FT == 0) begin
        if (t > 0) chk_lit("de_per_frame", 32'(de_cnt), 32'(S_HA * S_VA));
        de_cnt = 0;
      end
      if (de_s) de_cnt++;
      case (t)
        0: begin
          chk_lit("first_px", 32'({de_d, fs_d, vs_d, x_d, y_d}), 32'h0000_0000 | (32'b11 << 25));
          chk_lit("first_rgb", 32'({r_d, g_d, b_d}), 32'hFFFFFF);
        end
        159:  chk_lit("x159", 32'({r_d, g_d, b_d}), 32'hFFFFFF);
        160:  chk_lit("x160", 32'({r_d, g_d, b_d}), 32'hFFFF00);
        800:  chk_lit("x800", 32'({r_d, g_d, b_d}), 32'hFF0000);
        1279: chk_lit("x1279", 32'({de_d, r_d, g_d, b_d}), 32'h1000000);
        1280: chk_lit("x1280", 32'({de_d, r_d, g_d, b_d}), 32'h0);
        1389: chk_lit("hs_pre", 32'(hs_d), 32'd0);
        1390: chk_lit("hs_rise", 32'(hs_d), 32'd1);
        1429: chk_lit("hs_last", 32'(hs_d), 32'd1);
        1430: chk_lit("hs_fall", 32'(hs_d), 32'd0);
        1650: chk_lit("line1", 32'({fs_d, x_d, y_d}), 32'd1);
`ifdef VTG_SCROLL_EN
        281:  chk_lit("scroll_f1", 32'({r_s, g_s, b_s}), 32'hFFFF00);
`else
        281:  chk_lit("static_f1", 32'({r_s, g_s, b_s}), 32'hFFFFFF);
`endif
        16 * S_FT + 1: chk_lit("scroll_wrap", 32'({r_s, g_s, b_s}), 32'hFFFFFF);
        default: ;
      endcase
    end
  end

  initial begin
    int waited;
    rst_p = 1'b1;
    repeat (5) @(negedge clk);
    rst_p = 1'b0;
    repeat (6000) @(negedge clk);

    // Reset mid-frame: small raster line 3, pixel 10.
    waited = 0;
    while ((t % S_FT) != 94 && waited < 2 * S_FT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if ((t % S_FT) != 94) begin
      failures++;
      $display("FAIL midframe_wait t=%0d got=%0d exp=94", t, t % S_FT);
    end
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    repeat (3 * S_FT) @(negedge clk);

    // Random short resets over running video.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst_p = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_p = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
